fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_prog_rom.sv | 32 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: size defaults, instruction classes and FSM encoding.
package fetch_unit_pkg;

    localparam int DEF_INSTR_WIDTH = 20;
    localparam int DEF_ADDR_BITS   = 5;

    // Top two bits of an instruction word select its class in the control unit.
    localparam logic [1:0] CLS_RESET   = 2'b00;
    localparam logic [1:0] CLS_STD_OP  = 2'b01;
    localparam logic [1:0] CLS_LOAD_R  = 2'b10;
    localparam logic [1:0] CLS_STORE_R = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_prog_rom.sv
// Program memory for the fetch unit: synchronous write, 1-cycle synchronous read.
module prog_rom #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_BITS-1:0]   waddr_i,
    input  logic [INSTR_WIDTH-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [ADDR_BITS-1:0]   raddr_i,
    output logic [INSTR_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] rdata_q;

    // No reset on the array: program contents survive a core reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: loads a program in IDLE, then fetches/issues one word per next request.
// Optional halt-on-all-ones behaviour is enabled with the FETCH_UNIT_HALT_EN macro.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   next,
    input  logic                   jump_en,
    input  logic [ADDR_BITS-1:0]   jump_addr,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   halted,
    output fetch_state_e           dbg_state_o
);

    // An all-zero word decodes as the reset class and keeps the control unit parked.
    localparam logic [INSTR_WIDTH-1:0] RESET_WORD = {CLS_RESET, {(INSTR_WIDTH-2){1'b0}}};

    fetch_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] rom_rdata;
    logic                   rom_we;
    logic                   rom_re;

    // Loading is only allowed while parked, and reset wins over a pending write.
    assign rom_we = prog_we && (state_q == ST_IDLE) && !rst;
    assign rom_re = (state_q == ST_FETCH);

    prog_rom #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_prog_rom (
        .clk_i  (clk),
        .we_i   (rom_we),
        .waddr_i(prog_addr),
        .wdata_i(prog_data),
        .re_i   (rom_re),
        .raddr_i(pc_q),
        .rdata_o(rom_rdata)
    );

`ifdef FETCH_UNIT_HALT_EN
    logic halted_q, halted_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_UNIT_HALT_EN
        halted_d = halted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
`ifdef FETCH_UNIT_HALT_EN
                if (&rom_rdata) begin
                    state_d  = ST_HALT;
                    instr_d  = RESET_WORD;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    instr_d = rom_rdata;
                    valid_d = 1'b1;
                end
`else
                state_d = ST_HOLD;
                instr_d = rom_rdata;
                valid_d = 1'b1;
`endif
            end
            ST_HOLD: begin
                if (next) begin
                    state_d = ST_FETCH;
                    valid_d = 1'b0;
                    pc_d    = jump_en ? jump_addr : pc_q + ADDR_BITS'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= RESET_WORD;
            valid_q <= 1'b0;
`ifdef FETCH_UNIT_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_UNIT_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign dbg_state_o = state_q;

`ifdef FETCH_UNIT_HALT_EN
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program load, sequential/jump fetch, wrap, reset and halt cases.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int IW = 20;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          next = 1'b0;
    logic          jump_en = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    fetch_state_e  dbg_state;

    fetch_unit #(.INSTR_WIDTH(IW), .ADDR_BITS(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .next       (next),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    logic [IW-1:0]    mem_m [32];
    logic [IW+AW-1:0] exp_q [$];
    logic [AW-1:0]    cur_pc;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          je;
        logic [AW-1:0] ja;
        logic [AW-1:0] exp_pc;
    } step_t;

    step_t steps [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic prog_write(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic model_update);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        if (model_update) mem_m[a] = d;
    endtask

    // Pulses start or next for one edge, then waits for the issued word and checks it.
    task automatic pulse_and_wait(input logic use_start, input logic je, input logic [AW-1:0] ja,
                                  input logic [AW-1:0] exp_pc, input string name);
        int edges;
        logic [IW+AW-1:0] e;
        exp_q.push_back({mem_m[exp_pc], exp_pc});
        if (use_start) start = 1'b1;
        else begin
            next = 1'b1;
            jump_en = je;
            jump_addr = ja;
        end
        @(negedge clk);
        start = 1'b0;
        next = 1'b0;
        jump_en = 1'b0;
        edges = 1;
        while (!instr_valid && edges < 8) begin
            @(negedge clk);
            edges++;
        end
        chk({name, "_latency"}, 32'(edges), 32'd3);
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_instr"}, 32'(instr), 32'(e[IW+AW-1:AW]));
            chk({name, "_pc"}, 32'(pc), 32'(e[AW-1:0]));
        end
        cur_pc = exp_pc;
    endtask

    initial begin
        int p;
        steps[0] = '{1'b0, 5'd0,  5'd1};
        steps[1] = '{1'b0, 5'd0,  5'd2};
        steps[2] = '{1'b0, 5'd0,  5'd3};
        steps[3] = '{1'b1, 5'd17, 5'd17};
        steps[4] = '{1'b0, 5'd0,  5'd18};
        steps[5] = '{1'b1, 5'd30, 5'd30};
        steps[6] = '{1'b0, 5'd0,  5'd31};
        steps[7] = '{1'b0, 5'd0,  5'd0};
        steps[8] = '{1'b1, 5'd9,  5'd9};
        steps[9] = '{1'b0, 5'd0,  5'd10};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_instr", 32'(instr), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        for (int a = 0; a < 32; a++) begin
            logic [IW-1:0] w;
            w = IW'($urandom_range(0, 20'hFFFFE));
            if (a == 0) w = 20'h4A5B1;
            if (a == 1) w = 20'h80123;
            if (a == 2) w = 20'h0ABCD;
            prog_write(AW'(a), w, 1'b1);
        end

        pulse_and_wait(1'b1, 1'b0, '0, 5'd0, "start");
        for (int i = 0; i < 10; i++) begin
            pulse_and_wait(1'b0, steps[i].je, steps[i].ja, steps[i].exp_pc, $sformatf("step%0d", i));
        end

        // jump_en and start without next must leave the held word alone.
        @(negedge clk);
        jump_en = 1'b1;
        jump_addr = 5'd7;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("jump_alone_pc", 32'(pc), 32'(cur_pc));
        chk("jump_alone_instr", 32'(instr), 32'(mem_m[cur_pc]));
        chk("jump_alone_valid", 32'(instr_valid), 32'd1);
        chk("jump_alone_state", 32'(dbg_state), 32'(ST_HOLD));
        jump_en = 1'b0;
        start = 1'b0;

        // next held through FETCH and ISSUE counts only once.
        p = int'(cur_pc) + 1;
        exp_q.push_back({mem_m[p[AW-1:0]], p[AW-1:0]});
        next = 1'b1;
        repeat (3) @(negedge clk);
        next = 1'b0;
        chk("next_held_valid", 32'(instr_valid), 32'd1);
        begin
            logic [IW+AW-1:0] e;
            e = exp_q.pop_front();
            chk("next_held_instr", 32'(instr), 32'(e[IW+AW-1:AW]));
            chk("next_held_pc", 32'(pc), 32'(e[AW-1:0]));
        end
        @(negedge clk);
        chk("next_held_stable_pc", 32'(pc), 32'(p[AW-1:0]));
        chk("next_held_stable_valid", 32'(instr_valid), 32'd1);
        cur_pc = p[AW-1:0];

        // Program writes outside IDLE are dropped.
        prog_write(5'd2, 20'h12345, 1'b0);
        pulse_and_wait(1'b0, 1'b1, 5'd2, 5'd2, "we_in_hold");

        // Reset in the middle of a fetch.
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        chk("pre_rst_state", 32'(dbg_state), 32'(ST_FETCH));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_fetch_instr", 32'(instr), 32'd0);
        chk("rst_fetch_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_pc", 32'(pc), 32'd0);
        chk("rst_fetch_state", 32'(dbg_state), 32'(ST_IDLE));
        pulse_and_wait(1'b1, 1'b0, '0, 5'd0, "restart");
        pulse_and_wait(1'b0, 1'b0, '0, 5'd1, "restart_next");

        // All-ones word at address 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prog_write(5'd1, 20'hFFFFF, 1'b1);
        pulse_and_wait(1'b1, 1'b0, '0, 5'd0, "ones_start");
`ifdef FETCH_UNIT_HALT_EN
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_instr", 32'(instr), 32'd0);
        chk("halt_state", 32'(dbg_state), 32'(ST_HALT));
        next = 1'b1;
        repeat (4) @(negedge clk);
        next = 1'b0;
        chk("halt_next_ignored", 32'(dbg_state), 32'(ST_HALT));
        chk("halt_still_halted", 32'(halted), 32'd1);
`else
        pulse_and_wait(1'b0, 1'b0, '0, 5'd1, "ones_issue");
        chk("ones_not_halted", 32'(halted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
